tart_capture: RTL and testbench

- Parametrised antenna acquisition front end that replaces the fixed 24-channel capture, fake-data mux and sample-delay logic in the TART top level.
- Runs on the 6x fabric clock and synchronises NUM_ANTENNAS radio inputs.
- Samples once per RATIO clocks at a programmable phase, with selectable real or synthetic data.
- Writes samples into the dual-port block buffer and hands completed blocks to the SDRAM scheduler through a valid/ack handshake, with overflow detection.

---
 rtl/tart_capture.sv | 194 +++++++++++++++++++
 tb/tb_tart_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tart_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tart_capture
//  Purpose  : Antenna acquisition front end. Synchronises NUM_ANTENNAS radio
//             inputs onto the fabric clock, takes one sample per RATIO clocks
//             at a programmable phase, selects real or synthetic data, writes
//             samples into the dual-port block buffer and hands completed
//             blocks to the SDRAM scheduler with overflow detection.
//  Ports    : clk, rst               fabric clock, async active-high reset
//             antenna                raw receiver bits (asynchronous)
//             mode                   0 real, 1 counter, 2 LFSR, 3 pattern
//             aq_enable              acquisition enable
//             data_sample_delay      sample phase within the period
//             block_ack              scheduler drained the oldest block
//             overflow_clear         clears the sticky overflow flag
//             wr_en/wr_addr/wr_data  block-buffer write port
//             block_valid/index      completed-block pulse and its index
//             blocks_pending         completed blocks not yet acked
//             overflow               sticky dropped-sample flag
//             sample_phase           phase counter (debug)
//  Revision : 1.0  initial release
// ============================================================================
module tart_capture #(
    parameter int NUM_ANTENNAS = 24,
    parameter int RATIO        = 6,
    parameter int DELAY_BITS   = 3,
    parameter int ADDR_BITS    = 9,
    parameter int BLOCK_BITS   = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_ANTENNAS-1:0]         antenna,
    input  logic [1:0]                      mode,
    input  logic                            aq_enable,
    input  logic [DELAY_BITS-1:0]           data_sample_delay,
    input  logic                            block_ack,
    input  logic                            overflow_clear,
    output logic                            wr_en,
    output logic [ADDR_BITS-1:0]            wr_addr,
    output logic [NUM_ANTENNAS-1:0]         wr_data,
    output logic                            block_valid,
    output logic [ADDR_BITS-BLOCK_BITS-1:0] block_index,
    output logic [ADDR_BITS-BLOCK_BITS:0]   blocks_pending,
    output logic                            overflow,
    output logic [3:0]                      sample_phase
);

    localparam int          IDX_BITS   = ADDR_BITS - BLOCK_BITS;
    localparam int          PEND_BITS  = IDX_BITS + 1;
    localparam logic [31:0] NUM_BLOCKS = 32'(1) << IDX_BITS;
    localparam logic [31:0] MAX_PHASE  = 32'(RATIO - 1);
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_SEED  = 32'h0000_0001;
    localparam logic [31:0] PATTERN_A  = 32'h5555_5555;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [PEND_BITS-1:0] PEND_ONE  = PEND_BITS'(1);

    logic [NUM_ANTENNAS-1:0] s1_q, s2_q;
    logic [3:0]              phase_q, phase_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic                    pat_q, pat_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]    wr_addr_q, wr_addr_d;
    logic [NUM_ANTENNAS-1:0] wr_data_q, wr_data_d;
    logic                    block_valid_q, block_valid_d;
    logic [IDX_BITS-1:0]     block_index_q, block_index_d;
    logic [PEND_BITS-1:0]    pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic [3:0]              sample_phase_q, sample_phase_d;

    logic [31:0]             eff_delay;
    logic [31:0]             committed;
    logic [31:0]             src_word;
    logic                    sample;
    logic                    last_write;
    logic                    drop;
    logic                    accept;
    logic                    ack_eff;

    always_comb begin
        eff_delay = (32'(data_sample_delay) > MAX_PHASE) ? MAX_PHASE
                                                         : 32'(data_sample_delay);
        sample    = aq_enable && (32'(phase_q) == eff_delay);

        src_word = 32'(s2_q);
        unique case (mode)
            2'd0: src_word = 32'(s2_q);
            2'd1: src_word = cnt_q;
            2'd2: src_word = lfsr_q;
            2'd3: src_word = pat_q ? ~PATTERN_A : PATTERN_A;
        endcase

        // Completions still travelling through the wr_en -> block_valid ->
        // pending pipeline count as committed, so a closely following sample
        // cycle cannot overwrite a block the scheduler has not drained yet.
        last_write = wr_en_q && (&wr_addr_q[BLOCK_BITS-1:0]);
        committed  = 32'(pending_q) + 32'(block_valid_q) + 32'(last_write);
        drop       = sample && (addr_q[BLOCK_BITS-1:0] == '0)
                            && (committed >= NUM_BLOCKS);
        accept     = sample && !drop;

        phase_d = (32'(phase_q) == MAX_PHASE) ? 4'd0 : phase_q + 4'd1;

        // While disabled the address sits at the base of the current block,
        // discarding any partial block and resuming there on re-enable.
        if (!aq_enable) begin
            addr_d = {addr_q[ADDR_BITS-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};
        end else if (accept) begin
            addr_d = addr_q + ADDR_ONE;
        end else begin
            addr_d = addr_q;
        end

        cnt_d  = accept ? cnt_q + 32'd1 : cnt_q;
        lfsr_d = accept ? ({1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0))
                        : lfsr_q;
        pat_d  = accept ? ~pat_q : pat_q;

        wr_en_d   = accept;
        wr_data_d = accept ? src_word[NUM_ANTENNAS-1:0] : wr_data_q;
        // The address port follows every sample cycle, so a dropped sample
        // shows the held address with wr_en low.
        wr_addr_d = sample ? addr_q : wr_addr_q;

        block_valid_d = last_write;
        block_index_d = last_write ? wr_addr_q[ADDR_BITS-1:BLOCK_BITS] : block_index_q;

        ack_eff = block_ack && (pending_q != '0);
        unique case ({block_valid_q, ack_eff})
            2'b10:   pending_d = pending_q + PEND_ONE;
            2'b01:   pending_d = pending_q - PEND_ONE;
            default: pending_d = pending_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        sample_phase_d = phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            phase_q        <= '0;
            cnt_q          <= '0;
            lfsr_q         <= LFSR_SEED;
            pat_q          <= 1'b0;
            addr_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            block_valid_q  <= 1'b0;
            block_index_q  <= '0;
            pending_q      <= '0;
            overflow_q     <= 1'b0;
            sample_phase_q <= '0;
        end else begin
            s1_q           <= antenna;
            s2_q           <= s1_q;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            lfsr_q         <= lfsr_d;
            pat_q          <= pat_d;
            addr_q         <= addr_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            block_valid_q  <= block_valid_d;
            block_index_q  <= block_index_d;
            pending_q      <= pending_d;
            overflow_q     <= overflow_d;
            sample_phase_q <= sample_phase_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign block_valid    = block_valid_q;
    assign block_index    = block_index_q;
    assign blocks_pending = pending_q;
    assign overflow       = overflow_q;
    assign sample_phase   = sample_phase_q;

endmodule
`default_nettype wire

// File: tb/tb_tart_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tart_capture
//  Purpose  : Directed self-checking bench for tart_capture with default
//             parameters (24 antennas, RATIO 6, 4 blocks of 128 samples).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tart_capture;

    localparam logic [31:0] C_MASK = 32'h00FF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] antenna = '0;
    logic [1:0]  mode = 2'd1;
    logic        aq_enable = 1'b0;
    logic [2:0]  data_sample_delay = '0;
    logic        block_ack = 1'b0;
    logic        overflow_clear = 1'b0;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [23:0] wr_data;
    logic        block_valid;
    logic [1:0]  block_index;
    logic [2:0]  blocks_pending;
    logic        overflow;
    logic [3:0]  sample_phase;

    tart_capture dut (
        .clk               (clk),
        .rst               (rst),
        .antenna           (antenna),
        .mode              (mode),
        .aq_enable         (aq_enable),
        .data_sample_delay (data_sample_delay),
        .block_ack         (block_ack),
        .overflow_clear    (overflow_clear),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .block_valid       (block_valid),
        .block_index       (block_index),
        .blocks_pending    (blocks_pending),
        .overflow          (overflow),
        .sample_phase      (sample_phase)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int exp_cnt, exp_addr, exp_idx, exp_phase, src_mode;
    int n_wr, n_valid, ack_timer, step_n;
    bit auto_ack, ack_on_valid, stepped;
    logic [31:0] lfsr_tab [4] = '{32'h0000_0001, 32'h0020_0003,
                                  32'h0030_0002, 32'h0018_0001};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},   32'(wr_en),          32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr),        32'd0);
        check({tag, "_wr_data"}, 32'(wr_data),        32'd0);
        check({tag, "_valid"},   32'(block_valid),    32'd0);
        check({tag, "_index"},   32'(block_index),    32'd0);
        check({tag, "_pending"}, 32'(blocks_pending), 32'd0);
        check({tag, "_ovf"},     32'(overflow),       32'd0);
        check({tag, "_phase"},   32'(sample_phase),   32'd0);
    endtask

    // One clock: sample outputs 1 time unit after the edge and compare every
    // write and every block completion against the model.
    task automatic tick();
        logic [31:0] exp_d;
        @(posedge clk);
        #1;
        block_ack = 1'b0;
        if (stepped) step_n++;
        if (wr_en) begin
            case (src_mode)
                0:       exp_d = (stepped && step_n >= 3) ? 32'h00FF_FFFF : 32'h0;
                1:       exp_d = 32'(exp_cnt) & C_MASK;
                2:       exp_d = lfsr_tab[n_wr % 4] & C_MASK;
                default: exp_d = (n_wr % 2 == 1) ? 32'h00AA_AAAA : 32'h0055_5555;
            endcase
            check("wr_data",  32'(wr_data),      exp_d);
            check("wr_addr",  32'(wr_addr),      32'(exp_addr));
            check("wr_phase", 32'(sample_phase), 32'(exp_phase));
            exp_cnt++;
            exp_addr = (exp_addr + 1) % 512;
            n_wr++;
        end
        if (block_valid) begin
            check("blk_index", 32'(block_index), 32'(exp_idx));
            exp_idx = (exp_idx + 1) % 4;
            n_valid++;
            if (ack_on_valid) block_ack = 1'b1;
            if (auto_ack) ack_timer = 10;
        end else if (ack_timer > 0) begin
            ack_timer--;
            if (ack_timer == 0) block_ack = 1'b1;
        end
    endtask

    task automatic run_until_writes(input int target, input int budget);
        int n = 0;
        while (n_wr < target && n < budget) begin
            tick();
            n++;
        end
        check("write_budget", 32'(n_wr), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_cnt = 0; exp_addr = 0; exp_idx = 0; n_wr = 0;
        ack_timer = 0; stepped = 0; step_n = 0;
        block_ack = 1'b0; overflow_clear = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int snap;
        int k;
        auto_ack = 0; ack_on_valid = 0; n_valid = 0; src_mode = 1; exp_phase = 0;
        #3;
        check_outputs_zero("reset");

        // Counter mode, delay 2, acked blocks; index sequence wraps after 3
        do_reset();
        mode = 2'd1; data_sample_delay = 3'd2; exp_phase = 2; src_mode = 1;
        auto_ack = 1; aq_enable = 1'b1;
        repeat (3900) tick();
        check("valid_count", 32'(n_valid), 32'd5);
        check("acked_pending", 32'(blocks_pending), 32'd0);

        // Real data through the two-flop synchroniser
        auto_ack = 0;
        do_reset();
        mode = 2'd0; data_sample_delay = 3'd0; exp_phase = 0; src_mode = 0;
        antenna = '0;
        run_until_writes(5, 60);
        repeat (4) tick();
        #2;
        antenna = 24'hFF_FFFF; stepped = 1; step_n = 0;
        #1;
        run_until_writes(9, 60);
        antenna = '0;

        // Delay beyond the period clamps to the last phase
        do_reset();
        mode = 2'd1; data_sample_delay = 3'd7; exp_phase = 5; src_mode = 1;
        run_until_writes(8, 80);

        // LFSR and constant-pattern sources
        do_reset();
        mode = 2'd2; data_sample_delay = 3'd0; exp_phase = 0; src_mode = 2;
        run_until_writes(4, 40);
        do_reset();
        mode = 2'd3; src_mode = 3;
        run_until_writes(4, 40);

        // Overflow: no acks, buffer fills, sample at address 0 drops
        do_reset();
        mode = 2'd1; src_mode = 1;
        run_until_writes(512, 3200);
        repeat (20) tick();
        check("ovf_writes",  32'(n_wr),           32'd512);
        check("ovf_pending", 32'(blocks_pending), 32'd4);
        check("ovf_flag",    32'(overflow),       32'd1);
        check("ovf_addr",    32'(wr_addr),        32'd0);
        k = 0;
        while (sample_phase != 4'd5 && k < 8) begin
            tick();
            k++;
        end
        check("ovf_align", 32'(sample_phase), 32'd5);
        overflow_clear = 1'b1;        // coincides with a dropping sample cycle
        tick();
        overflow_clear = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        block_ack = 1'b1;
        tick();
        check("ack_pending", 32'(blocks_pending), 32'd3);
        run_until_writes(514, 30);
        check("resume_ovf", 32'(overflow), 32'd0);

        // Ack coincident with completion, and ack with nothing pending
        do_reset();
        run_until_writes(256, 1700);
        repeat (3) tick();
        check("pend_two", 32'(blocks_pending), 32'd2);
        ack_on_valid = 1;
        run_until_writes(384, 900);
        repeat (3) tick();
        ack_on_valid = 0;
        check("coincident_idx", 32'(exp_idx), 32'd3);
        check("coincident_pend", 32'(blocks_pending), 32'd2);
        block_ack = 1'b1; tick();
        block_ack = 1'b1; tick();
        check("pend_zero", 32'(blocks_pending), 32'd0);
        block_ack = 1'b1; tick();
        tick();
        check("ack_at_zero", 32'(blocks_pending), 32'd0);

        // Enable dropped mid-block 1 rewinds to 128
        do_reset();
        auto_ack = 1;
        run_until_writes(178, 1200);
        aq_enable = 1'b0;
        snap = n_valid;
        repeat (30) tick();
        check("disabled_writes", 32'(n_wr), 32'd178);
        check("disabled_valid", 32'(n_valid), 32'(snap));
        exp_addr = 128;
        aq_enable = 1'b1;
        run_until_writes(180, 30);
        auto_ack = 0;

        // Asynchronous reset mid-block clears outputs without an edge
        do_reset();
        run_until_writes(140, 1000);
        check("pre_rst_pending", 32'(blocks_pending), 32'd1);
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        snap = n_valid;
        do_reset();
        run_until_writes(2, 20);
        check("no_partial_valid", 32'(n_valid), 32'(snap));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
